// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and timer sizing.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Timer must hold the larger of the two phase lengths minus one.
  function automatic int unsigned timer_w(input int unsigned high_cycles,
                                          input int unsigned gap_cycles);
    int unsigned longest;
    longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_timer.sv
// Loadable down-counter that parks at zero; zero_c tells the FSM the phase is over.
module pulse_stretch_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into pulses of fixed high width and minimum low gap,
// queueing events that arrive mid-pulse and flagging any dropped at counter saturation.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned TW = timer_w(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state;
  state_t            state_next;
  logic [PEND_W-1:0] pending_next;
  logic              overflow_next;
  logic              timer_load;
  logic [TW-1:0]     timer_load_val;
  logic              timer_zero_c;
  logic              work_c;
  logic              enter_high_c;

  pulse_stretch_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_load_val),
    .zero_c  (timer_zero_c)
  );

  assign work_c = (pending != '0) || in;

  always_comb begin
    state_next     = state;
    pending_next   = pending;
    overflow_next  = overflow;
    timer_load     = 1'b0;
    timer_load_val = '0;
    enter_high_c   = 1'b0;

    case (state)
      IDLE: begin
        if (work_c) begin
          state_next     = HIGH;
          enter_high_c   = 1'b1;
          timer_load     = 1'b1;
          timer_load_val = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (timer_zero_c) begin
          state_next     = GAP;
          timer_load     = 1'b1;
          timer_load_val = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_zero_c) begin
          if (work_c) begin
            state_next     = HIGH;
            enter_high_c   = 1'b1;
            timer_load     = 1'b1;
            timer_load_val = HIGH_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A HIGH entry either bypasses the live event or consumes one queued event;
    // a queued consume with a simultaneous new event nets to zero.
    if (enter_high_c) begin
      if ((pending != '0) && !in) begin
        pending_next = pending - PEND_W'(1);
      end
    end else if (in) begin
      if (pending == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      overflow <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      out      <= (state_next == HIGH);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboarded bench for pulse_stretch: a phase-countdown reference model predicts each
// cycle's outputs, plus scenario checks on pulse counts and edge timing.
module tb_pulse_stretch;

  localparam int unsigned H = 4;
  localparam int unsigned G = 2;
  localparam int unsigned PW = 3;
  localparam int PMAX = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in = 1'b0;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  logic          reset1 = 1'b1;
  logic          in1 = 1'b0;
  logic          out1;
  logic          busy1;
  logic [PW-1:0] pending1;
  logic          overflow1;

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  pulse_stretch #(.HIGH_CYCLES(1), .GAP_CYCLES(1), .PEND_W(PW)) dut11 (
    .clk(clk), .reset(reset1), .in(in1), .out(out1), .busy(busy1),
    .pending(pending1), .overflow(overflow1)
  );

  typedef struct {
    int o;
    int b;
    int p;
    int v;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string scen = "init";

  // Reference model: phase 0 idle, 1 high, 2 gap; rem counts cycles left in phase.
  int m_ph = 0, m_rem = 0, m_pend = 0, m_ovf = 0;
  int obs_out, obs_busy, obs_pend, obs_ovf;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s/%s got=%0d expected=%0d", scen, tag, got, exp);
    end
  endtask

  task automatic model_step(input logic i, input logic r);
    bit work, enter;
    if (r) begin
      m_ph = 0; m_rem = 0; m_pend = 0; m_ovf = 0;
      return;
    end
    work  = (m_pend != 0) || i;
    enter = 0;
    case (m_ph)
      0: if (work) begin m_ph = 1; m_rem = H; enter = 1; end
      1: if (m_rem == 1) begin m_ph = 2; m_rem = G; end else m_rem--;
      default: begin
        if (m_rem == 1) begin
          if (work) begin m_ph = 1; m_rem = H; enter = 1; end
          else m_ph = 0;
        end else m_rem--;
      end
    endcase
    if (enter) begin
      if (m_pend != 0) m_pend = m_pend - 1 + int'(i);
    end else if (i) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end
  endtask

  task automatic step(input logic i, input logic r);
    exp_t e;
    @(negedge clk);
    in = i;
    reset = r;
    model_step(i, r);
    e.o = (m_ph == 1) ? 1 : 0;
    e.b = (m_ph != 0) ? 1 : 0;
    e.p = m_pend;
    e.v = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs_out  = int'(out);
    obs_busy = int'(busy);
    obs_pend = int'(pending);
    obs_ovf  = int'(overflow);
    if (sb.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_val("out", obs_out, e.o);
      check_val("busy", obs_busy, e.b);
      check_val("pending", obs_pend, e.p);
      check_val("overflow", obs_ovf, e.v);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    int highs, rises, prev, maxp;

    scen = "reset";
    do_reset();
    check_val("rst_out", obs_out, 0);
    check_val("rst_busy", obs_busy, 0);
    check_val("rst_pend", obs_pend, 0);
    check_val("rst_ovf", obs_ovf, 0);

    scen = "single";
    highs = 0;
    for (int e = 0; e <= 8; e++) begin
      step(e == 0, 1'b0);
      highs += obs_out;
      if (e == 3) check_val("e3_out", obs_out, 1);
      if (e == 4) check_val("e4_out", obs_out, 0);
      if (e == 5) check_val("e5_busy", obs_busy, 1);
      if (e == 6) check_val("e6_busy", obs_busy, 0);
      check_val("pend0", obs_pend, 0);
    end
    check_val("high_cycles", highs, 4);

    scen = "burst";
    do_reset();
    rises = 0; prev = 0;
    for (int e = 0; e <= 20; e++) begin
      step(e < 3, 1'b0);
      if (obs_out == 1 && prev == 0) rises++;
      prev = obs_out;
      if (e == 1) check_val("e1_pend", obs_pend, 1);
      if (e == 2) check_val("e2_pend", obs_pend, 2);
      if (e == 5) check_val("e5_gap", obs_out, 0);
      if (e == 6) check_val("e6_out", obs_out, 1);
      if (e == 17) check_val("e17_busy", obs_busy, 1);
      if (e == 18) check_val("e18_busy", obs_busy, 0);
    end
    check_val("pulses", rises, 3);

    scen = "saturate";
    do_reset();
    rises = 0; prev = 0;
    for (int e = 0; e <= 70; e++) begin
      step(e < 10, 1'b0);
      if (obs_out == 1 && prev == 0) rises++;
      prev = obs_out;
      if (e == 8) check_val("e8_pend", obs_pend, 7);
      if (e == 8) check_val("e8_ovf", obs_ovf, 0);
      if (e == 9) check_val("e9_ovf", obs_ovf, 1);
    end
    // 10 events, one dropped at saturation
    check_val("pulses", rises, 9);
    check_val("ovf_sticky", obs_ovf, 1);
    check_val("drained", obs_pend, 0);
    check_val("idle", obs_busy, 0);

    scen = "bypass";
    do_reset();
    maxp = 0;
    for (int e = 0; e <= 14; e++) begin
      step(e == 0 || e == 6, 1'b0);
      if (obs_pend > maxp) maxp = obs_pend;
      if (e == 3) check_val("e3_out", obs_out, 1);
      if (e == 4) check_val("e4_out", obs_out, 0);
      if (e == 5) check_val("e5_out", obs_out, 0);
      if (e == 6) check_val("e6_out", obs_out, 1);
      if (e == 9) check_val("e9_out", obs_out, 1);
      if (e == 10) check_val("e10_out", obs_out, 0);
    end
    check_val("max_pend", maxp, 0);

    scen = "midreset";
    do_reset();
    for (int e = 0; e <= 2; e++) step(e < 2 || e == 2, e == 2);
    check_val("out", obs_out, 0);
    check_val("busy", obs_busy, 0);
    check_val("pend", obs_pend, 0);
    check_val("ovf", obs_ovf, 0);
    step(1'b0, 1'b0);
    highs = 0;
    for (int e = 0; e <= 8; e++) begin
      step(e == 0, 1'b0);
      highs += obs_out;
      if (e == 6) check_val("e6_busy", obs_busy, 0);
    end
    check_val("high_cycles", highs, 4);

    scen = "h1g1";
    @(negedge clk); reset1 = 1'b1; in1 = 1'b0;
    @(negedge clk); reset1 = 1'b1;
    @(posedge clk); #1;
    check_val("rst_out", int'(out1), 0);
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      reset1 = 1'b0;
      in1 = 1'b1;
      @(posedge clk); #1;
      check_val($sformatf("e%0d_out", e), int'(out1), (e % 2 == 0) ? 1 : 0);
      check_val($sformatf("e%0d_pend", e), int'(pending1), (e + 1) / 2);
    end
    @(negedge clk); in1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
